// File: rtl/cla_pipe_top.sv
// Free-running BIST: LFSR operands -> pipelined CLA, checked against a delayed behavioural sum.
// Latency WIDTH/BLOCK cycles, one add per cycle; no backpressure (free-running, nothing stalls).

module cla_pipe #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);
  localparam int STAGES = WIDTH / BLOCK;

  // Two-level lookahead: c[j+1] = g[j] | p[j]g[j-1] | ... | p[j..0]c0
  function automatic logic [BLOCK:0] group_carries(input logic [BLOCK-1:0] g,
                                                   input logic [BLOCK-1:0] p,
                                                   input logic             c0);
    logic [BLOCK:0] c;
    logic           pp;
    c    = '0;
    c[0] = c0;
    for (int j = 0; j < BLOCK; j++) begin
      pp = 1'b1;
      for (int m = j; m >= 0; m--) begin
        c[j+1] = c[j+1] | (g[m] & pp);
        pp     = pp & p[m];
      end
      c[j+1] = c[j+1] | (pp & c0);
    end
    return c;
  endfunction

  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_q [STAGES];
  logic [WIDTH-1:0] a_d [STAGES];
  logic [WIDTH-1:0] b_d [STAGES];
  logic [WIDTH-1:0] s_d [STAGES];
  logic             c_d [STAGES];
  logic [WIDTH-1:0] a_x [STAGES];
  logic [WIDTH-1:0] b_x [STAGES];
  logic [WIDTH-1:0] s_x [STAGES];
  logic             c_x [STAGES];
  logic [BLOCK-1:0] ga, gb;
  logic [BLOCK:0]   gc;

  // Stage k sees the operands and partial sum held by stage k-1 and fills in group k.
  always_comb begin
    ga     = '0;
    gb     = '0;
    gc     = '0;
    a_x[0] = a_i;
    b_x[0] = b_i;
    s_x[0] = '0;
    c_x[0] = cin_i;
    for (int k = 1; k < STAGES; k++) begin
      a_x[k] = a_q[k-1];
      b_x[k] = b_q[k-1];
      s_x[k] = s_q[k-1];
      c_x[k] = c_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      ga     = a_x[k][k*BLOCK +: BLOCK];
      gb     = b_x[k][k*BLOCK +: BLOCK];
      gc     = group_carries(ga & gb, ga ^ gb, c_x[k]);
      a_d[k] = a_x[k];
      b_d[k] = b_x[k];
      s_d[k] = s_x[k];
      s_d[k][k*BLOCK +: BLOCK] = (ga ^ gb) ^ gc[BLOCK-1:0];
      c_d[k] = gc[BLOCK];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
      end
    end
  end

  assign sum_o  = s_q[STAGES-1];
  assign cout_o = c_q[STAGES-1];
endmodule

module cla_pipe_top #(
  parameter int          WIDTH       = 32,
  parameter int          BLOCK       = 4,
  parameter int          LOCK_CYCLES = 16,
  parameter logic [31:0] SEED_A      = 32'h1234_5678,
  parameter logic [31:0] SEED_B      = 32'h9ABC_DEF1
) (
  input  logic user_clk,
  input  logic rst,
  input  logic en,
  output logic error,
  output logic locked
);
  localparam int          STAGES = WIDTH / BLOCK;
  localparam int          CW     = $clog2(LOCK_CYCLES + 1);
  localparam logic [31:0] TAPS   = 32'h8020_0003;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  logic [31:0]      lfsr_a_q, lfsr_a_d, lfsr_b_q, lfsr_b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             locked_q, locked_d;
  logic             error_q, error_d;
  logic [WIDTH:0]   ref_q [STAGES];
  logic [STAGES-1:0] vld_q;

  logic [WIDTH-1:0] op_a, op_b, cla_sum;
  logic             cin, cla_cout;
  logic [WIDTH:0]   ref_in, chk;

  assign op_a   = lfsr_a_q[WIDTH-1:0];
  assign op_b   = lfsr_b_q[WIDTH-1:0];
  assign cin    = op_a[0] ^ op_b[WIDTH-1];
  assign ref_in = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, cin};
  // en only perturbs the compared copy; the pipeline itself is untouched.
  assign chk    = {cla_cout, cla_sum ^ {{(WIDTH-1){1'b0}}, en}};

  cla_pipe #(.WIDTH(WIDTH), .BLOCK(BLOCK)) u_cla (
    .clk_i  (user_clk),
    .rst_ni (rst),
    .a_i    (op_a),
    .b_i    (op_b),
    .cin_i  (cin),
    .sum_o  (cla_sum),
    .cout_o (cla_cout)
  );

  always_comb begin
    cnt_d    = cnt_q;
    locked_d = locked_q;
    lfsr_a_d = lfsr_a_q;
    lfsr_b_d = lfsr_b_q;
    error_d  = error_q;
    if (!locked_q) begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(LOCK_CYCLES - 1)) locked_d = 1'b1;
    end else begin
      lfsr_a_d = lfsr_step(lfsr_a_q);
      lfsr_b_d = lfsr_step(lfsr_b_q);
    end
    if (vld_q[STAGES-1] && (chk != ref_q[STAGES-1])) error_d = 1'b1;
  end

  always_ff @(posedge user_clk or negedge rst) begin
    if (!rst) begin
      lfsr_a_q <= SEED_A;
      lfsr_b_q <= SEED_B;
      cnt_q    <= '0;
      locked_q <= 1'b0;
      error_q  <= 1'b0;
      vld_q    <= '0;
      for (int k = 0; k < STAGES; k++) ref_q[k] <= '0;
    end else begin
      lfsr_a_q <= lfsr_a_d;
      lfsr_b_q <= lfsr_b_d;
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
      error_q  <= error_d;
      vld_q    <= {vld_q[STAGES-2:0], locked_q};
      ref_q[0] <= ref_in;
      for (int k = 1; k < STAGES; k++) ref_q[k] <= ref_q[k-1];
    end
  end

  assign error  = error_q;
  assign locked = locked_q;
endmodule

// File: tb/tb_cla_pipe_top.sv
// Directed bench for cla_pipe_top plus a standalone cla_pipe for forced-operand adds.
module tb_cla_pipe_top;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic        error, locked;
  logic        cla_rst_n = 1'b0;
  logic [31:0] cla_a = '0, cla_b = '0;
  logic        cla_cin = 1'b0;
  logic [31:0] cla_sum;
  logic        cla_cout;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  cla_pipe_top dut (
    .user_clk (clk),
    .rst      (rst),
    .en       (en),
    .error    (error),
    .locked   (locked)
  );

  cla_pipe #(.WIDTH(32), .BLOCK(4)) u_cla (
    .clk_i  (clk),
    .rst_ni (cla_rst_n),
    .a_i    (cla_a),
    .b_i    (cla_b),
    .cin_i  (cla_cin),
    .sum_o  (cla_sum),
    .cout_o (cla_cout)
  );

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; cla_rst_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (error !== 1'b0) begin n_err++; $display("FAIL reset_error cyc %0d got %b want 0", i, error); end
      n_cmp++;
      if (locked !== 1'b0) begin n_err++; $display("FAIL reset_locked cyc %0d got %b want 0", i, locked); end
    end
    n_cmp++;
    if ({cla_cout, cla_sum} !== 33'h0) begin
      n_err++; $display("FAIL cla_reset got %h want 0", {cla_cout, cla_sum});
    end
  endtask

  task automatic test_lock();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      if (i == 15 || i == 16) begin
        n_cmp++;
        if (locked !== (i == 16)) begin
          n_err++; $display("FAIL lock_edge_%0d got %b want %b", i, locked, (i == 16));
        end
      end
    end
    n_cmp++;
    if (error !== 1'b0) begin n_err++; $display("FAIL lock_error got %b want 0", error); end
  endtask

  task automatic test_free_run();
    for (int i = 1; i <= 2000; i++) begin
      @(posedge clk); #1;
      if (i % 250 == 0) begin
        n_cmp++;
        if (error !== 1'b0) begin n_err++; $display("FAIL free_run_error cyc %0d got %b want 0", i, error); end
      end
    end
    n_cmp++;
    if (locked !== 1'b1) begin n_err++; $display("FAIL free_run_locked got %b want 1", locked); end
  endtask

  task automatic test_cla_latency();
    @(negedge clk);
    cla_rst_n = 1'b1;
    cla_a = 32'hFFFF_FFFF; cla_b = 32'h0000_0001; cla_cin = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk); #1;
      cla_a = '0; cla_b = '0; cla_cin = 1'b0;
      if (e == 7) begin
        n_cmp++;
        if (cla_cout !== 1'b0) begin n_err++; $display("FAIL cla_early_edge7 cout got %b want 0", cla_cout); end
      end
    end
    n_cmp++;
    if ({cla_cout, cla_sum} !== {1'b1, 32'h0000_0000}) begin
      n_err++; $display("FAIL cla_ffff_plus_1 got %h want 1_00000000", {cla_cout, cla_sum});
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] va [8];
    logic [31:0] vb [8];
    logic        vc [8];
    logic [32:0] vr [8];
    va[0] = 32'h0000_0000; vb[0] = 32'h0000_0000; vc[0] = 1'b1; vr[0] = 33'h0_0000_0001;
    va[1] = 32'h1234_5678; vb[1] = 32'h1111_1111; vc[1] = 1'b0; vr[1] = 33'h0_2345_6789;
    va[2] = 32'h8000_0000; vb[2] = 32'h8000_0000; vc[2] = 1'b1; vr[2] = 33'h1_0000_0001;
    va[3] = 32'h0000_000F; vb[3] = 32'h0000_0001; vc[3] = 1'b0; vr[3] = 33'h0_0000_0010;
    va[4] = 32'h7FFF_FFFF; vb[4] = 32'h0000_0000; vc[4] = 1'b1; vr[4] = 33'h0_8000_0000;
    va[5] = 32'hFFFF_FFFF; vb[5] = 32'hFFFF_FFFF; vc[5] = 1'b1; vr[5] = 33'h1_FFFF_FFFF;
    va[6] = 32'hA5A5_A5A5; vb[6] = 32'h5A5A_5A5A; vc[6] = 1'b0; vr[6] = 33'h0_FFFF_FFFF;
    va[7] = 32'hA5A5_A5A5; vb[7] = 32'h5A5A_5A5A; vc[7] = 1'b1; vr[7] = 33'h1_0000_0000;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (c < 8) begin cla_a = va[c]; cla_b = vb[c]; cla_cin = vc[c]; end
      else begin cla_a = '0; cla_b = '0; cla_cin = 1'b0; end
      @(posedge clk); #1;
      if (c >= 7) begin
        n_cmp++;
        if ({cla_cout, cla_sum} !== vr[c-7]) begin
          n_err++; $display("FAIL cla_vec_%0d got %h want %h", c - 7, {cla_cout, cla_sum}, vr[c-7]);
        end
      end
    end
  endtask

  task automatic test_fault_inject();
    repeat (20) @(posedge clk);
    #1;
    n_cmp++;
    if (error !== 1'b0) begin n_err++; $display("FAIL inject_pre got %b want 0", error); end
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    n_cmp++;
    if (error !== 1'b1) begin n_err++; $display("FAIL inject_set got %b want 1", error); end
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (error !== 1'b1) begin n_err++; $display("FAIL inject_sticky got %b want 1", error); end
    n_cmp++;
    if (locked !== 1'b1) begin n_err++; $display("FAIL inject_locked got %b want 1", locked); end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (error !== 1'b0) begin n_err++; $display("FAIL midrst_error got %b want 0", error); end
    n_cmp++;
    if (locked !== 1'b0) begin n_err++; $display("FAIL midrst_locked got %b want 0", locked); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      if (i == 3) begin
        // en during lock wait must not be checked
        en = 1'b1;
      end else begin
        en = 1'b0;
      end
      if (i == 15 || i == 16) begin
        n_cmp++;
        if (locked !== (i == 16)) begin
          n_err++; $display("FAIL relock_edge_%0d got %b want %b", i, locked, (i == 16));
        end
      end
    end
    repeat (3) @(posedge clk);
    #1;
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    n_cmp++;
    if (error !== 1'b0) begin n_err++; $display("FAIL fill_en_ignored got %b want 0", error); end
    repeat (50) @(posedge clk);
    #1;
    n_cmp++;
    if (error !== 1'b0) begin n_err++; $display("FAIL relock_error got %b want 0", error); end
    n_cmp++;
    if (locked !== 1'b1) begin n_err++; $display("FAIL relock_locked got %b want 1", locked); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_free_run();
    test_cla_latency();
    test_back_to_back();
    test_fault_inject();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
